// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register file access arbiter.
package rf_arb_pkg;

   localparam int REG_AW = 5;
   localparam int XLEN   = 32;

   localparam logic [REG_AW-1:0] REG_X0 = 5'd0;

   // Port ids double as bit positions in the request/grant vectors.
   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_DBG  = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      RESP
   } state_t;

   // One accepted request, held for the whole access.
   typedef struct packed {
      logic              we;
      logic [REG_AW-1:0] addr;
      logic [XLEN-1:0]   wdata;
      logic              port;
   } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. The grant is combinational from the
// requests; the last-served port only moves when the owner signals a
// completed handshake via advance.
module rr_arb2
   import rf_arb_pkg::*;
#(
   parameter int CORE_FIRST = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   // Pretend the other port was served last so the preferred one wins first.
   localparam logic LAST_RST = (CORE_FIRST != 0) ? PORT_DBG : PORT_CORE;

   logic last_grant;

   // Pick the lone requester, or the port not served last when both ask.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      gnt = req;
      if (&req) begin
         gnt = (last_grant == PORT_CORE) ? 2'b10 : 2'b01;
      end
   end

   // Remember who was served, only on an actual handshake.
   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= LAST_RST;
      end else if (advance && (|gnt)) begin
         last_grant <= gnt[PORT_DBG];
      end
   end

endmodule

// File: rtl/rf_access_arbiter.sv
// Shares the single register file access port between the core sequencer
// and the debug loader: one request at a time, round-robin, one access
// cycle, read latency wait, then a one-cycle response to the winner.
// Register x0 is hardwired to zero.
module rf_access_arbiter
   import rf_arb_pkg::*;
#(
   parameter int RD_LATENCY = 1,
   parameter int CORE_FIRST = 1
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              core_req_valid,
   output logic              core_req_ready,
   input  logic              core_req_we,
   input  logic [REG_AW-1:0] core_req_addr,
   input  logic [XLEN-1:0]   core_req_wdata,
   output logic              core_rsp_valid,

   input  logic              dbg_req_valid,
   output logic              dbg_req_ready,
   input  logic              dbg_req_we,
   input  logic [REG_AW-1:0] dbg_req_addr,
   input  logic [XLEN-1:0]   dbg_req_wdata,
   output logic              dbg_rsp_valid,

   output logic [XLEN-1:0]   rsp_rdata,

   output logic              rf_we,
   output logic              rf_re,
   output logic [REG_AW-1:0] rf_addr,
   output logic [XLEN-1:0]   rf_wdata,
   input  logic [XLEN-1:0]   rf_rdata
);

   // Enough to count RD_LATENCY-1 for latencies up to 4.
   localparam int CNT_W = 2;

   state_t            state;
   req_t              lat;
   req_t              sel_req;
   logic [CNT_W-1:0]  wait_cnt;
   logic [XLEN-1:0]   rsp_q;
   logic              arb_en;
   logic [1:0]        arb_req;
   logic [1:0]        gnt;
   logic              handshake;

   // Requests are only visible to the arbiter in IDLE and outside reset.
   assign arb_en    = (state == IDLE) && !rst;
   assign arb_req   = {dbg_req_valid, core_req_valid} & {2{arb_en}};
   assign handshake = |gnt;

   rr_arb2 #(
      .CORE_FIRST (CORE_FIRST)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (arb_req),
      .advance (arb_en),
      .gnt     (gnt)
   );

   assign core_req_ready = gnt[PORT_CORE];
   assign dbg_req_ready  = gnt[PORT_DBG];

   // Mux the winning port's payload for the request latch.
   always_comb begin
      sel_req = '{we: core_req_we, addr: core_req_addr,
                  wdata: core_req_wdata, port: PORT_CORE};
      if (gnt[PORT_DBG]) begin
         sel_req = '{we: dbg_req_we, addr: dbg_req_addr,
                     wdata: dbg_req_wdata, port: PORT_DBG};
      end
   end

   // Capture the accepted request; it is only consumed outside IDLE.
   // NOTE: this payload register has no reset; state gates every use of it.
   always_ff @(posedge clk) begin
      if (handshake) begin
         lat <= sel_req;
      end
   end

   // Access sequencer: accept, drive one access cycle, wait out the read
   // latency, then hold the response for one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
         rsp_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (handshake) begin
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               if (lat.we) begin
                  rsp_q <= '0;
                  state <= RESP;
               end else begin
                  wait_cnt <= CNT_W'(RD_LATENCY - 1);
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  rsp_q <= (lat.addr == REG_X0) ? '0 : rf_rdata;
                  state <= RESP;
               end else begin
                  wait_cnt <= wait_cnt - CNT_W'(1);
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Register file strobes decoded from state and the latched request;
   // x0 accesses never reach the register file.
   always_comb begin
      rf_we    = 1'b0;
      rf_re    = 1'b0;
      rf_addr  = '0;
      rf_wdata = '0;
      if (state == ACCESS) begin
         rf_addr = lat.addr;
         if (lat.we) begin
            rf_we    = (lat.addr != REG_X0);
            rf_wdata = lat.wdata;
         end else begin
            rf_re = (lat.addr != REG_X0);
         end
      end
   end

   assign core_rsp_valid = (state == RESP) && (lat.port == PORT_CORE);
   assign dbg_rsp_valid  = (state == RESP) && (lat.port == PORT_DBG);
   assign rsp_rdata      = rsp_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Bench for rf_access_arbiter: a latency-1 instance driven through both
// ports with a response scoreboard, plus a latency-3 instance for the
// long-read timing.
module tb_rf_access_arbiter;

   localparam logic [31:0] JUNK = 32'hA5A5_A5A5;

   logic clk;
   logic rst;
   int   cyc;
   int   total;
   int   bad;

   // Latency-1 instance signals; index 0 = core, 1 = dbg.
   logic [1:0]  v;
   logic [1:0]  we;
   logic [4:0]  addr [2];
   logic [31:0] wd   [2];
   logic        c_rdy, d_rdy, c_rsp, d_rsp;
   logic [1:0]  rdy;
   logic [31:0] rsp_rdata;
   logic        rf_we, rf_re;
   logic [4:0]  rf_addr;
   logic [31:0] rf_wdata, rf_rdata;

   // Latency-3 instance signals.
   logic        v3;
   logic        c3_rdy, d3_rdy, c3_rsp, d3_rsp;
   logic [31:0] rsp3;
   logic        rf3_we, rf3_re;
   logic [4:0]  rf3_addr;
   logic [31:0] rf3_wdata, rf3_rdata;

   typedef struct {
      int          port;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t sb [$];
   int   grant_port [$];
   int   grant_cyc  [$];

   assign rdy = {d_rdy, c_rdy};

   rf_access_arbiter #(.RD_LATENCY(1), .CORE_FIRST(1)) dut (
      .clk            (clk),
      .rst            (rst),
      .core_req_valid (v[0]),
      .core_req_ready (c_rdy),
      .core_req_we    (we[0]),
      .core_req_addr  (addr[0]),
      .core_req_wdata (wd[0]),
      .core_rsp_valid (c_rsp),
      .dbg_req_valid  (v[1]),
      .dbg_req_ready  (d_rdy),
      .dbg_req_we     (we[1]),
      .dbg_req_addr   (addr[1]),
      .dbg_req_wdata  (wd[1]),
      .dbg_rsp_valid  (d_rsp),
      .rsp_rdata      (rsp_rdata),
      .rf_we          (rf_we),
      .rf_re          (rf_re),
      .rf_addr        (rf_addr),
      .rf_wdata       (rf_wdata),
      .rf_rdata       (rf_rdata)
   );

   rf_access_arbiter #(.RD_LATENCY(3), .CORE_FIRST(1)) dut3 (
      .clk            (clk),
      .rst            (rst),
      .core_req_valid (v3),
      .core_req_ready (c3_rdy),
      .core_req_we    (1'b0),
      .core_req_addr  (5'd9),
      .core_req_wdata (32'd0),
      .core_rsp_valid (c3_rsp),
      .dbg_req_valid  (1'b0),
      .dbg_req_ready  (d3_rdy),
      .dbg_req_we     (1'b0),
      .dbg_req_addr   (5'd0),
      .dbg_req_wdata  (32'd0),
      .dbg_rsp_valid  (d3_rsp),
      .rsp_rdata      (rsp3),
      .rf_we          (rf3_we),
      .rf_re          (rf3_re),
      .rf_addr        (rf3_addr),
      .rf_wdata       (rf3_wdata),
      .rf_rdata       (rf3_rdata)
   );

   // Register file models: data appears exactly RD_LATENCY cycles after
   // rf_re; every other cycle shows junk.
   logic [31:0] mem1 [32] = '{0: 32'hBAD0_BAD0, 1: 32'h1111_0001,
                              2: 32'h2222_0002, default: 32'hC0DE_0000};
   logic [31:0] pipe1;
   logic [31:0] mem3 [32] = '{9: 32'h0000_0008, default: 32'hC0DE_0000};
   logic [31:0] pipe3 [3];

   always @(posedge clk) begin
      if (rf_we) mem1[rf_addr] <= rf_wdata;
      pipe1 <= rf_re ? mem1[rf_addr] : JUNK;
   end
   assign rf_rdata = pipe1;

   always @(posedge clk) begin
      if (rf3_we) mem3[rf3_addr] <= rf3_wdata;
      pipe3[0] <= rf3_re ? mem3[rf3_addr] : JUNK;
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign rf3_rdata = pipe3[2];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at 500000, required to finish earlier");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_req_ready"}, 32'(rdy), 32'd0);
      check({tag, "_rsp_valid"}, 32'({d_rsp, c_rsp}), 32'd0);
      check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      check({tag, "_rf_we"}, 32'(rf_we), 32'd0);
      check({tag, "_rf_re"}, 32'(rf_re), 32'd0);
      check({tag, "_rf_addr"}, 32'(rf_addr), 32'd0);
      check({tag, "_rf_wdata"}, rf_wdata, 32'd0);
   endtask

   // Response monitor: pops the scoreboard whenever a response pulse shows.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (c_rsp || d_rsp) begin
            check("rsp_onehot", 32'(c_rsp & d_rsp), 32'd0);
            if (sb.size() == 0) begin
               total = total + 1;
               bad   = bad + 1;
               $display("FAIL unexpected_rsp: got rsp_valid core=%0b dbg=%0b, expected none (cycle %0d)",
                        c_rsp, d_rsp, cyc);
            end else begin
               e = sb.pop_front();
               check("rsp_port", 32'(d_rsp), 32'(e.port));
               check("rsp_rdata", rsp_rdata, e.data);
               check("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
         end
         if (rf_we) check("rf_we_addr_nonzero", 32'(rf_addr != 5'd0), 32'd1);
      end
   end

   // Present one request on port p (caller sits at a falling edge), wait for
   // the handshake, log the expected response and check the access cycle.
   task automatic issue(input int p, input logic w, input logic [4:0] a,
                        input logic [31:0] d, input logic [31:0] exp_d);
      bit   got;
      int   hs;
      exp_t e;
      got   = 1'b0;
      v[p]  = 1'b1;
      we[p] = w;
      addr[p] = a;
      wd[p] = d;
      for (int n = 0; n < 60; n++) begin
         #1;
         if (rdy[p] === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!got) begin
         v[p]  = 1'b0;
         total = total + 1;
         bad   = bad + 1;
         $display("FAIL handshake_timeout: port %0d got no ready in 60 cycles, expected ready=1", p);
         return;
      end
      hs     = cyc;
      e.port = p;
      e.data = exp_d;
      e.cyc  = hs + (w ? 2 : 3);
      sb.push_back(e);
      grant_port.push_back(p);
      grant_cyc.push_back(hs);
      @(negedge clk);
      v[p] = 1'b0;
      #1;
      check("access_rf_we", 32'(rf_we), 32'(w && (a != 5'd0)));
      check("access_rf_re", 32'(rf_re), 32'(!w && (a != 5'd0)));
      check("access_rf_addr", 32'(rf_addr), 32'(a));
      if (w && (a != 5'd0)) check("access_rf_wdata", rf_wdata, d);
      check("access_ready_low", 32'(rdy), 32'd0);
   endtask

   initial begin
      int c0;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      v     = 2'b00;
      we    = 2'b00;
      addr[0] = 5'd0; addr[1] = 5'd0;
      wd[0]   = 32'd0; wd[1]  = 32'd0;
      v3    = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      check_idle_zero("reset");
      check("reset_l3_rsp", 32'({d3_rsp, c3_rsp}), 32'd0);
      check("reset_l3_rf_re", 32'(rf3_re), 32'd0);
      rst = 1'b0;

      // Both ports valid continuously: grants alternate starting with core.
      fork
         begin
            for (int i = 0; i < 4; i++) issue(0, 1'b0, 5'd1, 32'd0, 32'h1111_0001);
         end
         begin
            for (int i = 0; i < 4; i++) issue(1, 1'b0, 5'd2, 32'd0, 32'h2222_0002);
         end
      join
      check("arb_grant_count", 32'(grant_port.size()), 32'd8);
      for (int i = 0; i < grant_port.size(); i++) begin
         check("arb_grant_port", 32'(grant_port[i]), 32'(i % 2));
         if (i > 0) check("arb_read_gap", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd4);
      end

      // Core write x5 then read it back; write throughput is 3 cycles.
      issue(0, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'd0);
      issue(0, 1'b0, 5'd5, 32'd0, 32'hDEAD_BEEF);
      check("write_gap", 32'(grant_cyc[9] - grant_cyc[8]), 32'd3);

      // x0 is hardwired: write is dropped, read returns zero.
      issue(1, 1'b1, 5'd0, 32'h1234_5678, 32'd0);
      issue(1, 1'b0, 5'd0, 32'd0, 32'd0);

      repeat (8) @(negedge clk);
      check("sb_drained_1", 32'(sb.size()), 32'd0);

      // RD_LATENCY = 3: read x9 with a second request held pending.
      v3 = 1'b1;
      #1;
      check("l3_hs_ready", 32'(c3_rdy), 32'd1);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         #1;
         check("l3_rf_re", 32'(rf3_re), 32'(k == 1));
         check("l3_ready_low", 32'(c3_rdy), 32'd0);
         check("l3_rsp_valid", 32'(c3_rsp), 32'(k == 5));
         if (k == 1) check("l3_rf_addr", 32'(rf3_addr), 32'd9);
         if (k == 5) check("l3_rdata", rsp3, 32'h0000_0008);
      end
      @(negedge clk);
      #1;
      check("l3_ready_again", 32'(c3_rdy), 32'd1);
      @(negedge clk);
      v3 = 1'b0;
      repeat (8) @(negedge clk);

      // Reset during the WAIT cycle of a read drops it silently.
      v[0] = 1'b1; we[0] = 1'b0; addr[0] = 5'd1;
      #1;
      check("rst_hs_ready", 32'(c_rdy), 32'd1);
      @(negedge clk);
      v[0] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_idle_zero("after_rst");
      rst = 1'b0;
      c0  = cyc;
      issue(1, 1'b1, 5'd3, 32'hCAFE_F00D, 32'd0);
      check("rst_accept_cycle", 32'(grant_cyc[grant_cyc.size()-1] - c0), 32'd0);

      repeat (8) @(negedge clk);
      check("sb_drained_2", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rf_access_arbiter.md
# rf_access_arbiter

- Shares the single access port of the 32×32-bit integer register file between two requesters: the core sequencer (port 0, `core_*`) and the debug/test loader (port 1, `dbg_*`).
- Accepts one request at a time under round-robin arbitration and drives the register file for exactly one access cycle.
- Waits out the register file read latency and returns a one-cycle response to the requester that won.
- Sits between the non-pipelined control unit, the debug interface and `reg_file`. Hardwires x0 to zero.

## Interface

Parameters:
- `RD_LATENCY`, default 1 — cycles from `rf_re` to valid `rf_rdata`; legal range 1..4.
- `CORE_FIRST`, default 1 — after reset, which port wins the first contested grant: 1 = core, 0 = debug.

Ports (`<p>` is `core` or `dbg`):
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `<p>_req_valid` in 1 — request present.
- `<p>_req_ready` out 1 — request accepted this cycle.
- `<p>_req_we` in 1 — 1 = write, 0 = read.
- `<p>_req_addr` in 5 — register index.
- `<p>_req_wdata` in 32 — write data.
- `<p>_rsp_valid` out 1 — one-cycle response pulse.
- `rsp_rdata` out 32 — read data; shared by both ports, qualified by `<p>_rsp_valid`.
- `rf_we` out 1 — register file write enable.
- `rf_re` out 1 — register file read enable.
- `rf_addr` out 5 — register file address.
- `rf_wdata` out 32 — register file write data.
- `rf_rdata` in 32 — register file read data, valid `RD_LATENCY` cycles after `rf_re`.

## Operation

FSM states: IDLE, ACCESS, WAIT, RESP.
- **IDLE**
  - Combinationally asserts `req_ready` to at most one port that has `req_valid` high.
  - On a handshake (`valid && ready`): latch we/addr/wdata and the port id, then go to ACCESS.
  - If neither port is valid: stay in IDLE.
- **ACCESS** (exactly one cycle)
  - Drive `rf_addr` from the latched request.
  - Write: drive `rf_wdata`, assert `rf_we`, go to RESP.
  - Read: assert `rf_re`, load the wait counter with `RD_LATENCY`-1, go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter is 0: capture `rf_rdata` into the response register and go to RESP.
- **RESP** (exactly one cycle)
  - Assert `<p>_rsp_valid` for the latched port only, then go to IDLE.

Arbitration:
- Single requester: that requester wins.
- Both requesters valid: the port not served last wins.
- The `last_grant` register updates only on a handshake.
- Reset value of `last_grant` is set so the port selected by `CORE_FIRST` wins the first contest.

Register x0:
- Write to address 0: `rf_we` stays 0, the response is still given, `rsp_rdata` = 0.
- Read of address 0: `rf_re` stays 0, the same WAIT timing is kept, and 32'h0 is captured instead of `rf_rdata`.

Other rules:
- Write responses carry `rsp_rdata` = 0.
- `req_ready` is 0 in every state except IDLE. Requesters hold valid and payload until ready.
- Responses have no backpressure. A requester must be able to take a response at any time.

## Timing

Handshake at edge N, counted in cycles after the IDLE cycle:
- Write: `rf_we` high in cycle N+1, `rsp_valid` high in N+2, next `req_ready` possible in N+3.
- Read: `rf_re` high in N+1, `rf_rdata` sampled at the end of cycle N+1+`RD_LATENCY`, `rsp_valid` high in N+2+`RD_LATENCY`.
- Throughput: one access per 3 cycles (write) or 3+`RD_LATENCY` cycles (read).

Reset:
- State returns to IDLE.
- All outputs are 0: `req_ready`, `rsp_valid`, `rsp_rdata`, `rf_we`, `rf_re`, `rf_addr`, `rf_wdata`.
- Reset mid-operation drops the in-flight request silently: no response pulse and no further `rf_we`/`rf_re`.
- A write already issued in ACCESS is not undone.

Signal timing:
- `rf_*` outputs are decoded from registered state and latched fields. No combinational path from `req_*` to `rf_*`.
- `req_ready` is combinational from `req_valid`, state and `last_grant`.

## Structure

- Package `rf_arb_pkg`:
  - state enum (IDLE/ACCESS/WAIT/RESP);
  - port ids `PORT_CORE` = 0, `PORT_DBG` = 1;
  - `REG_X0` = 5'd0;
  - `REG_AW` = 5 and `XLEN` = 32.
- Sub-module `rr_arb2`:
  - two-input round-robin arbiter with `last_grant` register;
  - inputs `req[1:0]` and an `advance` strobe; output one-hot `gnt[1:0]`.
- FSM, request latch, wait counter and response register stay in `rf_access_arbiter`.

## Test plan

- Core-only write x5 = 32'hDEADBEEF at edge N:
  - `rf_we` = 1, `rf_addr` = 5 in N+1;
  - `core_rsp_valid` in N+2;
  - then a core read of x5 with `RD_LATENCY` = 1 returns `rsp_rdata` = 32'hDEADBEEF, `core_rsp_valid` 3 cycles after its handshake.
- Both ports valid continuously, reads of x1/x2:
  - grants alternate core, dbg, core, dbg, starting with core when `CORE_FIRST` = 1;
  - no port gets two consecutive grants while the other is valid.
- Debug write x0 = 32'h12345678:
  - `rf_we` never asserts and `dbg_rsp_valid` pulses;
  - a subsequent read of x0 returns 0 with `rf_re` = 0.
- `RD_LATENCY` = 3, read of x9 where the model returns 32'h8:
  - `rf_re` in N+1, sample in N+4, `rsp_valid` in N+5 with data 32'h8;
  - `req_ready` = 0 from N+1 through N+5.
- Assert `rst` in the WAIT cycle of a read:
  - no `rsp_valid` follows;
  - all outputs are 0 the next cycle;
  - a new request is accepted in IDLE immediately after `rst` deasserts.
